// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: 1149.1 state encoding and next-state function.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_RUN_IDLE   = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_TLR        = 4'hF
  } tap_state_t;

  // TAP state after one TCK rising edge with the given TMS.
  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TAP_TLR;
    case (s)
      TAP_TLR:        n = tms ? TAP_TLR       : TAP_RUN_IDLE;
      TAP_RUN_IDLE:   n = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_DR:  n = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   n = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   n = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   n = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  n = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_IR:  n = tms ? TAP_TLR       : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   n = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   n = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   n = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  n = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      default:        n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_tracker.sv
// Oversamples the BSCAN pins in the clk domain and tracks the TAP state.
module jtag_tap_tracker
  import jtag_pkg::*;
#(
  parameter int unsigned NUM_CHAN    = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                jtag_reset,
  input  logic                jtag_tck,
  input  logic                jtag_tms,
  input  logic                jtag_tdi,
  input  logic [NUM_CHAN-1:0] jtag_sel,
  output tap_state_t          state,
  output logic                tck_rise_c,
  output logic                tck_fall_c,
  output logic                tdi_sync,
  output logic [NUM_CHAN-1:0] sel_sync
);

  localparam int unsigned IN_W = 4 + NUM_CHAN;

  logic [IN_W-1:0] pipe [SYNC_STAGES];
  logic [IN_W-1:0] synced;
  logic            tck_prev;
  tap_state_t      state_nxt;

  // Synchroniser chain for all JTAG inputs, plus previous TCK for edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) pipe[s] <= '0;
      tck_prev <= 1'b0;
    end else begin
      pipe[0] <= {jtag_sel, jtag_reset, jtag_tdi, jtag_tms, jtag_tck};
      for (int s = 1; s < SYNC_STAGES; s++) pipe[s] <= pipe[s-1];
      tck_prev <= synced[0];
    end
  end

  assign synced     = pipe[SYNC_STAGES-1];
  assign tck_rise_c = synced[0] & ~tck_prev;
  assign tck_fall_c = ~synced[0] & tck_prev;
  assign tdi_sync   = synced[2];
  assign sel_sync   = synced[IN_W-1:4];

  // TAP state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= TAP_TLR;
    else        state <= state_nxt;
  end

  // TAP next state: BSCAN reset dominates, otherwise advance on TCK rise.
  always_comb begin
    state_nxt = state;
    if (synced[3])       state_nxt = TAP_TLR;
    else if (tck_rise_c) state_nxt = tap_next(state, synced[1]);
  end

endmodule

// File: rtl/jtag_user_dr_bridge.sv
// Multi-channel JTAG user-DR mailbox: shared shift register, per-channel rx/tx ports.
module jtag_user_dr_bridge
  import jtag_pkg::*;
#(
  parameter int unsigned NUM_CHAN    = 2,
  parameter int unsigned DR_WIDTH    = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         jtag_reset,
  input  logic                         jtag_tck,
  input  logic                         jtag_tms,
  input  logic                         jtag_tdi,
  input  logic [NUM_CHAN-1:0]          jtag_sel,
  output logic                         jtag_tdo,
  output logic [NUM_CHAN*DR_WIDTH-1:0] rx_data,
  output logic [NUM_CHAN-1:0]          rx_valid,
  input  logic [NUM_CHAN-1:0]          rx_ready,
  output logic [NUM_CHAN-1:0]          rx_overrun,
  input  logic [NUM_CHAN*DR_WIDTH-1:0] tx_data,
  input  logic [NUM_CHAN-1:0]          tx_valid,
  output logic [NUM_CHAN-1:0]          tx_ready
);

  localparam int unsigned CH_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  tap_state_t          state;
  logic                tck_rise_c;
  logic                tck_fall_c;
  logic                tdi_sync;
  logic [NUM_CHAN-1:0] sel_sync;

  logic [DR_WIDTH:0]   sr;
  logic [CH_W-1:0]     cur_ch;
  logic [CH_W-1:0]     act_ch_c;
  logic                act_any_c;
  logic [DR_WIDTH-1:0] tx_word_c;
  logic                cap_c;
  logic                shift_c;
  logic                upd_c;
  logic [NUM_CHAN-1:0] tx_ready_nxt;

  jtag_tap_tracker #(
    .NUM_CHAN    (NUM_CHAN),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_tap (
    .clk        (clk),
    .rst_n      (rst_n),
    .jtag_reset (jtag_reset),
    .jtag_tck   (jtag_tck),
    .jtag_tms   (jtag_tms),
    .jtag_tdi   (jtag_tdi),
    .jtag_sel   (jtag_sel),
    .state      (state),
    .tck_rise_c (tck_rise_c),
    .tck_fall_c (tck_fall_c),
    .tdi_sync   (tdi_sync),
    .sel_sync   (sel_sync)
  );

  // Lowest-index selected chain wins.
  always_comb begin
    act_ch_c  = '0;
    act_any_c = 1'b0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (sel_sync[i]) begin
        act_ch_c  = CH_W'(i);
        act_any_c = 1'b1;
      end
    end
  end

  // DR actions, decoded from the TAP state before the edge's transition.
  always_comb begin
    tx_word_c    = tx_data[act_ch_c*DR_WIDTH +: DR_WIDTH];
    cap_c        = tck_rise_c && (state == TAP_CAPTURE_DR) && act_any_c;
    shift_c      = tck_rise_c && (state == TAP_SHIFT_DR) && sel_sync[cur_ch];
    upd_c        = tck_fall_c && (state == TAP_UPDATE_DR) && sel_sync[cur_ch] && sr[DR_WIDTH];
    tx_ready_nxt = '0;
    if (cap_c && tx_valid[act_ch_c]) tx_ready_nxt[act_ch_c] = 1'b1;
  end

  // Shared shift register, channel latch, TDO and tx handshake pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr       <= '0;
      cur_ch   <= '0;
      jtag_tdo <= 1'b0;
      tx_ready <= '0;
    end else begin
      tx_ready <= tx_ready_nxt;
      if (cap_c) begin
        cur_ch <= act_ch_c;
        sr     <= {tx_valid[act_ch_c], tx_valid[act_ch_c] ? tx_word_c : DR_WIDTH'(0)};
      end else if (shift_c) begin
        sr <= {tdi_sync, sr[DR_WIDTH:1]};
      end
      if (tck_fall_c) jtag_tdo <= sr[0];
    end
  end

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_ch
    logic [DR_WIDTH-1:0] data_q;
    logic                valid_q;
    logic                ovr_q;
    logic                hit_c;

    assign hit_c = upd_c && (cur_ch == CH_W'(i));

    // Host->SoC mailbox word with sticky overrun on a dropped write.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end else if (hit_c) begin
        if (!valid_q || rx_ready[i]) begin
          data_q  <= sr[DR_WIDTH-1:0];
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx_ready[i]) begin
        valid_q <= 1'b0;
      end
    end

    assign rx_data[i*DR_WIDTH +: DR_WIDTH] = data_q;
    assign rx_valid[i]   = valid_q;
    assign rx_overrun[i] = ovr_q;
  end

endmodule

// File: tb/tb_jtag_user_dr_bridge.sv
// Directed bench for jtag_user_dr_bridge: BSCAN pin-level scans, mailbox checks.
module tb_jtag_user_dr_bridge;
  import jtag_pkg::*;

  localparam int unsigned NC = 2;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          jtag_reset;
  logic          jtag_tck;
  logic          jtag_tms;
  logic          jtag_tdi;
  logic [NC-1:0] jtag_sel;
  logic          jtag_tdo;
  logic [NC*DW-1:0] rx_data;
  logic [NC-1:0] rx_valid;
  logic [NC-1:0] rx_ready;
  logic [NC-1:0] rx_overrun;
  logic [NC*DW-1:0] tx_data;
  logic [NC-1:0] tx_valid;
  logic [NC-1:0] tx_ready;

  int total = 0;
  int bad   = 0;
  int txr_cnt0 = 0;
  int txr_cnt1 = 0;

  jtag_user_dr_bridge #(.NUM_CHAN(NC), .DR_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .jtag_reset(jtag_reset), .jtag_tck(jtag_tck),
    .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_sel(jtag_sel), .jtag_tdo(jtag_tdo),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_ready[0]) txr_cnt0++;
    if (tx_ready[1]) txr_cnt1++;
  end

  // One TCK period; optional one-clk rx_ready[0] pulse aligned to the update after the fall.
  task automatic tck_cycle(input logic tms, input logic tdi, input bit rdy_pulse, output logic tdo_s);
    @(negedge clk);
    jtag_tms = tms;
    jtag_tdi = tdi;
    repeat (4) @(negedge clk);
    tdo_s = jtag_tdo;
    jtag_tck = 1'b1;
    repeat (6) @(negedge clk);
    jtag_tck = 1'b0;
    if (rdy_pulse) begin
      repeat (2) @(negedge clk);
      rx_ready[0] = 1'b1;
      @(negedge clk);
      rx_ready[0] = 1'b0;
    end
    repeat (6) @(negedge clk);
  endtask

  // Full 33-bit DR scan from TLR/RTI back to RTI; din[0] shifted first.
  task automatic scan_dr(input logic [DW:0] din, input bit rdy_pulse, output logic [DW:0] dout);
    logic t;
    tck_cycle(1'b0, 1'b0, 1'b0, t);
    tck_cycle(1'b1, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, 1'b0, t);
    for (int i = 0; i <= DW; i++) begin
      tck_cycle((i == DW) ? 1'b1 : 1'b0, din[i], 1'b0, t);
      dout[i] = t;
    end
    tck_cycle(1'b1, 1'b0, rdy_pulse, t);
    tck_cycle(1'b0, 1'b0, 1'b0, t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic t;
    do_reset();
    if ({jtag_tdo, rx_data, rx_valid, rx_overrun, tx_ready} !== '0) begin
      $display("FAIL reset_outputs got=%h exp=0", {jtag_tdo, rx_data, rx_valid, rx_overrun, tx_ready});
      bad++;
    end
    total++;
    if (dut.u_tap.state !== TAP_TLR) begin
      $display("FAIL reset_tap got=%h exp=%h", dut.u_tap.state, TAP_TLR);
      bad++;
    end
    total++;
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, 1'b0, t);
    if (dut.u_tap.state !== TAP_TLR) begin
      $display("FAIL tms_hold_tlr got=%h exp=%h", dut.u_tap.state, TAP_TLR);
      bad++;
    end
    total++;
  endtask

  task automatic test_write_ch0();
    logic [DW:0] dout;
    jtag_sel = 2'b01;
    scan_dr({1'b1, 32'hDEADBEEF}, 1'b0, dout);
    if (rx_valid !== 2'b01) begin
      $display("FAIL wr0_valid got=%b exp=01", rx_valid); bad++;
    end
    total++;
    if (rx_data[31:0] !== 32'hDEADBEEF) begin
      $display("FAIL wr0_data got=%h exp=deadbeef", rx_data[31:0]); bad++;
    end
    total++;
    if (dout !== 33'h0) begin
      $display("FAIL wr0_tdo got=%h exp=0", dout); bad++;
    end
    total++;
  endtask

  task automatic test_read_ch1();
    logic [DW:0] dout;
    int c0, c1;
    c0 = txr_cnt0; c1 = txr_cnt1;
    tx_data[63:32] = 32'h12345678;
    tx_valid = 2'b10;
    jtag_sel = 2'b10;
    scan_dr(33'h0, 1'b0, dout);
    tx_valid = 2'b00;
    if (dout !== 33'h1_12345678) begin
      $display("FAIL rd1_tdo got=%h exp=112345678", dout); bad++;
    end
    total++;
    if ((txr_cnt1 - c1) !== 1 || (txr_cnt0 - c0) !== 0) begin
      $display("FAIL rd1_tx_ready got=%0d/%0d exp=1/0", txr_cnt1 - c1, txr_cnt0 - c0); bad++;
    end
    total++;
    if (rx_valid[1] !== 1'b0) begin
      $display("FAIL rd1_no_rx got=%b exp=0", rx_valid[1]); bad++;
    end
    total++;
  endtask

  task automatic test_overrun();
    logic [DW:0] dout;
    @(negedge clk); rx_ready[0] = 1'b1;
    @(negedge clk); rx_ready[0] = 1'b0;
    @(negedge clk);
    if (rx_valid[0] !== 1'b0 || rx_data[31:0] !== 32'hDEADBEEF) begin
      $display("FAIL consume got=%b/%h exp=0/deadbeef", rx_valid[0], rx_data[31:0]); bad++;
    end
    total++;
    jtag_sel = 2'b01;
    scan_dr({1'b1, 32'h11111111}, 1'b0, dout);
    if (rx_valid[0] !== 1'b1 || rx_overrun[0] !== 1'b0) begin
      $display("FAIL ovr_first got=%b/%b exp=1/0", rx_valid[0], rx_overrun[0]); bad++;
    end
    total++;
    scan_dr({1'b1, 32'h22222222}, 1'b0, dout);
    if (rx_data[31:0] !== 32'h11111111) begin
      $display("FAIL ovr_data got=%h exp=11111111", rx_data[31:0]); bad++;
    end
    total++;
    if (rx_overrun !== 2'b01) begin
      $display("FAIL ovr_flag got=%b exp=01", rx_overrun); bad++;
    end
    total++;
  endtask

  task automatic test_empty_read_jreset();
    logic [DW:0] dout;
    logic t;
    int c1;
    c1 = txr_cnt1;
    jtag_sel = 2'b10;
    tx_valid = 2'b00;
    scan_dr(33'h0, 1'b0, dout);
    if (dout !== 33'h0 || (txr_cnt1 - c1) !== 0) begin
      $display("FAIL empty_read got=%h/%0d exp=0/0", dout, txr_cnt1 - c1); bad++;
    end
    total++;
    tck_cycle(1'b0, 1'b0, 1'b0, t);
    tck_cycle(1'b1, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, 1'b0, t);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'b1, 1'b0, t);
    @(negedge clk); jtag_reset = 1'b1;
    repeat (6) @(negedge clk);
    if (dut.u_tap.state !== TAP_TLR) begin
      $display("FAIL jreset_tap got=%h exp=%h", dut.u_tap.state, TAP_TLR); bad++;
    end
    total++;
    jtag_reset = 1'b0;
    for (int i = 0; i < 3; i++) tck_cycle(1'b1, 1'b1, 1'b0, t);
    if (rx_valid[1] !== 1'b0 || rx_overrun[1] !== 1'b0) begin
      $display("FAIL jreset_no_rx got=%b/%b exp=0/0", rx_valid[1], rx_overrun[1]); bad++;
    end
    total++;
  endtask

  task automatic test_back_to_back();
    logic [DW:0] dout;
    do_reset();
    if (rx_overrun !== 2'b00 || rx_valid !== 2'b00) begin
      $display("FAIL b2b_reset got=%b/%b exp=00/00", rx_overrun, rx_valid); bad++;
    end
    total++;
    jtag_sel = 2'b11;
    scan_dr({1'b1, 32'hAAAA5555}, 1'b0, dout);
    if (rx_valid !== 2'b01 || rx_data[31:0] !== 32'hAAAA5555) begin
      $display("FAIL b2b_first got=%b/%h exp=01/aaaa5555", rx_valid, rx_data[31:0]); bad++;
    end
    total++;
    scan_dr({1'b1, 32'h5A5A5A5A}, 1'b1, dout);
    if (rx_data[31:0] !== 32'h5A5A5A5A || rx_valid !== 2'b01) begin
      $display("FAIL b2b_data got=%h/%b exp=5a5a5a5a/01", rx_data[31:0], rx_valid); bad++;
    end
    total++;
    if (rx_overrun !== 2'b00 || rx_data[63:32] !== 32'h0) begin
      $display("FAIL b2b_ovr got=%b/%h exp=00/0", rx_overrun, rx_data[63:32]); bad++;
    end
    total++;
  endtask

  initial begin
    rst_n = 1'b1; jtag_reset = 1'b0; jtag_tck = 1'b0; jtag_tms = 1'b1; jtag_tdi = 1'b0;
    jtag_sel = '0; rx_ready = '0; tx_data = '0; tx_valid = '0;
    test_reset();
    test_write_ch0();
    test_read_ch1();
    test_overrun();
    test_empty_read_jreset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
